seg7_scan_decoder: RTL and testbench

- Monitors the anode/cathode lines of a time-multiplexed 7-segment display and rebuilds the hex digit shown on each position. This is the inverse of the hex-to-segment decoder.
- Used as an in-design checker/loopback on the display bus. Also usable as a capture front-end for externally driven displays.
- Filters scan transitions and ghosting with a stability counter. Flags illegal segment patterns. Detects loss of scanning.

---
 rtl/seg7_pkg.sv | 40 ++++
 rtl/seg7_pattern_to_hex.sv | 27 ++
 rtl/seg7_scan_decoder.sv | 191 +++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment forward decoder and the inverse
// scan decoder:
//   - SEG_W / seg7_t : segment bus width and bit order {g,f,e,d,c,b,a}
//   - SEG7_TABLE     : active-low segment patterns for hex digits 0-F
//   - ST_LOST/TRACK  : scan decoder state encoding
//   - hex_to_seg()   : forward lookup, nibble -> segment pattern
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam int unsigned SEG_W = 7;

  // Segment lines as they appear on the cathode bus, MSB first.
  typedef struct packed {
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg7_t;

  localparam logic [0:0] ST_LOST  = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;

  // Active-low cathode patterns, index = hex value.
  localparam logic [SEG_W-1:0] SEG7_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
    return SEG7_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg7_pattern_to_hex.sv
// -----------------------------------------------------------------------------
// seg7_pattern_to_hex
// Combinational inverse of the hex-to-segment table.
//   pattern : active-low segment pattern {g,f,e,d,c,b,a}
//   nibble  : hex value whose pattern matches (0 when no match)
//   valid   : pattern is one of the 16 table entries
// -----------------------------------------------------------------------------
module seg7_pattern_to_hex
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [3:0]       nibble,
  output logic             valid
);

  always_comb begin
    nibble = '0;
    valid  = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (pattern == SEG7_TABLE[i]) begin
        nibble = 4'(i);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
// Watches the anode/cathode lines of a multiplexed 7-segment display and
// rebuilds the hex digit shown on each position.
//   clk, rst     : clock, synchronous active-high reset
//   an           : digit enables, active-low, bit i = digit i
//   seg          : cathodes, active-low, {g,f,e,d,c,b,a}
//   digits       : decoded nibbles, digit i at [4i+3:4i]
//   digit_valid  : digit i committed since reset / loss
//   err          : last dwell on digit i carried an unknown pattern
//   update       : one-cycle pulse per commit
//   frame_done   : one-cycle pulse once every digit has committed
//   lost         : high while no scanning is observed
// -----------------------------------------------------------------------------
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [SEG_W-1:0]        seg,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   err,
  output logic                    update,
  output logic                    frame_done,
  output logic                    lost
);

  localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(STABLE_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  // Input sample and the sample before it
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [NUM_DIGITS-1:0] an_prev_q, an_prev_d;
  seg7_t                 seg_q, seg_d;
  seg7_t                 seg_prev_q, seg_prev_d;

  // Stability tracking
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             committed_q, committed_d;
  logic             sample_same;
  logic             one_low;
  logic             commit;

  // Captured display state
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    update_q, update_d;
  logic                    frame_done_q, frame_done_d;

  // Scan supervision
  logic [0:0]        state_q, state_d;
  logic [IDLE_W-1:0] idle_q, idle_d;

  logic [3:0] dec_nibble;
  logic       dec_valid;

  seg7_pattern_to_hex u_dec (
    .pattern (seg_q),
    .nibble  (dec_nibble),
    .valid   (dec_valid)
  );

  // Sampling and stability counter. The counter looks at the registered
  // sample against the one before it, so a value stable at the pins from
  // edge k reaches a full count at edge k+STABLE_CYCLES.
  always_comb begin
    an_d       = an;
    seg_d      = seg;
    an_prev_d  = an_q;
    seg_prev_d = seg_q;

    sample_same = (an_q == an_prev_q) && (seg_q == seg_prev_q);
    one_low     = ($countones(~an_q) == 1);

    if (!sample_same) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_FULL) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    commit = sample_same && (cnt_d == CNT_FULL) && !committed_q && one_low;

    if (!sample_same) begin
      committed_d = 1'b0;
    end else begin
      committed_d = committed_q | commit;
    end
  end

  // Commit, seen-mask and timeout handling
  always_comb begin
    digits_d     = digits_q;
    valid_d      = valid_q;
    err_d        = err_q;
    seen_d       = seen_q;
    update_d     = commit;
    frame_done_d = 1'b0;
    state_d      = state_q;
    idle_d       = idle_q;

    // A full mask is cleared here; a commit in the same cycle is applied
    // below, so it lands in the fresh mask.
    if (&seen_q) begin
      frame_done_d = 1'b1;
      seen_d       = '0;
    end

    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (commit && !an_q[i]) begin
        seen_d[i] = 1'b1;
        if (dec_valid) begin
          digits_d[4*i +: 4] = dec_nibble;
          valid_d[i]         = 1'b1;
          err_d[i]           = 1'b0;
        end else begin
          err_d[i] = 1'b1;
        end
      end
    end

    // Commit takes priority over an expiring idle count.
    if (commit) begin
      state_d = ST_TRACK;
      idle_d  = '0;
    end else if (state_q == ST_TRACK) begin
      if (idle_q == IDLE_LAST) begin
        state_d = ST_LOST;
        idle_d  = '0;
        valid_d = '0;
        err_d   = '0;
        seen_d  = '0;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q         <= '1;
      an_prev_q    <= '1;
      seg_q        <= '1;
      seg_prev_q   <= '1;
      cnt_q        <= '0;
      committed_q  <= 1'b0;
      digits_q     <= '0;
      valid_q      <= '0;
      err_q        <= '0;
      seen_q       <= '0;
      update_q     <= 1'b0;
      frame_done_q <= 1'b0;
      state_q      <= ST_LOST;
      idle_q       <= '0;
    end else begin
      an_q         <= an_d;
      an_prev_q    <= an_prev_d;
      seg_q        <= seg_d;
      seg_prev_q   <= seg_prev_d;
      cnt_q        <= cnt_d;
      committed_q  <= committed_d;
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      seen_q       <= seen_d;
      update_q     <= update_d;
      frame_done_q <= frame_done_d;
      state_q      <= state_d;
      idle_q       <= idle_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign err         = err_q;
  assign update      = update_q;
  assign frame_done  = frame_done_q;
  assign lost        = (state_q == ST_LOST);

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
// Directed stimulus for seg7_scan_decoder (STABLE_CYCLES=4, TIMEOUT_CYCLES=64).
// Each dwell that should commit pushes its hand-computed result and commit
// cycle into a queue; a monitor pops and compares on every update pulse.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

  localparam int unsigned S = 4;
  localparam int unsigned T = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic [3:0]  err;
  logic        update;
  logic        frame_done;
  logic        lost;

  seg7_scan_decoder #(
    .NUM_DIGITS     (4),
    .STABLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .an          (an),
    .seg         (seg),
    .digits      (digits),
    .digit_valid (digit_valid),
    .err         (err),
    .update      (update),
    .frame_done  (frame_done),
    .lost        (lost)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned t;
    logic [15:0] d;
    logic [3:0]  v;
    logic [3:0]  e;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          fd_cnt = 0;
  int          upd_cnt = 0;
  int          pushed = 0;
  int unsigned last_t = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t x;
    if (frame_done) fd_cnt++;
    if (update) begin
      upd_cnt++;
      check("update_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        check("update_cycle", cyc, x.t);
        check("digits_at_update", 32'(digits), 32'(x.d));
        check("valid_at_update", 32'(digit_valid), 32'(x.v));
        check("err_at_update", 32'(err), 32'(x.e));
        check("lost_at_update", 32'(lost), 32'd0);
      end
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called #1 after a posedge: pins are first sampled on the next edge k,
  // so a commit is due at edge k+S.
  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int unsigned n,
                       input bit commit, input logic [15:0] ed, input logic [3:0] ev,
                       input logic [3:0] ee);
    an  = a;
    seg = s;
    if (commit) begin
      exp_q.push_back('{cyc + 1 + S, ed, ev, ee});
      pushed++;
      last_t = cyc + 1 + S;
    end
    step(n);
  endtask

  task automatic blank(input int unsigned n);
    dwell(4'b1111, 7'h7F, n, 1'b0, '0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    an  = 4'b1111;
    seg = 7'h7F;
    step(3);
    check("reset_digits", 32'(digits), 32'd0);
    check("reset_valid", 32'(digit_valid), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_lost", 32'(lost), 32'd1);
    check("reset_update", 32'(update), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    step(2);

    // Single long dwell: one commit only
    dwell(4'b1110, 7'h40, 20, 1'b1, 16'h0000, 4'b0001, 4'b0000);
    check("single_updates", upd_cnt, 1);
    check("single_valid", 32'(digit_valid), 32'h1);
    check("single_lost", 32'(lost), 32'd0);
    blank(3);

    // Full sweep
    dwell(4'b1110, 7'h79, 8, 1'b1, 16'h0001, 4'b0001, 4'b0000); blank(2);
    dwell(4'b1101, 7'h24, 8, 1'b1, 16'h0021, 4'b0011, 4'b0000); blank(2);
    dwell(4'b1011, 7'h30, 8, 1'b1, 16'h0321, 4'b0111, 4'b0000); blank(2);
    dwell(4'b0111, 7'h19, 8, 1'b1, 16'h4321, 4'b1111, 4'b0000); blank(2);
    check("sweep_frame_done", fd_cnt, 1);
    check("sweep_updates", upd_cnt, 5);
    check("sweep_digits", 32'(digits), 32'h4321);
    check("sweep_valid", 32'(digit_valid), 32'hF);

    // Glitches shorter than S, then two anodes low
    dwell(4'b1101, 7'h24, 2, 1'b0, '0, '0, '0);
    dwell(4'b1101, 7'h30, 3, 1'b0, '0, '0, '0);
    blank(3);
    dwell(4'b1100, 7'h40, 10, 1'b0, '0, '0, '0);
    blank(3);
    check("glitch_updates", upd_cnt, 5);
    check("glitch_digits", 32'(digits), 32'h4321);

    // Bad pattern on digit 2
    dwell(4'b1011, 7'h12, 8, 1'b1, 16'h4521, 4'b1111, 4'b0000); blank(2);
    dwell(4'b1011, 7'h7F, 6, 1'b1, 16'h4521, 4'b1111, 4'b0100); blank(2);
    check("bad_err", 32'(err), 32'h4);
    check("bad_digit2", 32'(digits[11:8]), 32'h5);
    dwell(4'b1011, 7'h0E, 8, 1'b1, 16'h4F21, 4'b1111, 4'b0000); blank(2);
    check("recover_err", 32'(err), 32'h0);
    check("recover_digit2", 32'(digits[11:8]), 32'hF);

    // Second sweep, then loss of scanning
    dwell(4'b1110, 7'h79, 8, 1'b1, 16'h4F21, 4'b1111, 4'b0000); blank(2);
    dwell(4'b1101, 7'h24, 8, 1'b1, 16'h4F21, 4'b1111, 4'b0000); blank(2);
    dwell(4'b1011, 7'h30, 8, 1'b1, 16'h4321, 4'b1111, 4'b0000); blank(2);
    dwell(4'b0111, 7'h19, 8, 1'b1, 16'h4321, 4'b1111, 4'b0000);
    an  = 4'b1111;
    seg = 7'h7F;
    check("sweep2_frame_done", fd_cnt, 2);
    while (cyc < last_t + T - 1) @(negedge clk);
    check("lost_before_timeout", 32'(lost), 32'd0);
    @(negedge clk);
    check("lost_at_timeout", 32'(lost), 32'd1);
    check("lost_valid", 32'(digit_valid), 32'd0);
    check("lost_err", 32'(err), 32'd0);
    check("lost_digits", 32'(digits), 32'h4321);
    @(posedge clk);
    #1;
    blank(2);

    // Reset during the 3rd cycle of a 4-cycle dwell
    an  = 4'b1110;
    seg = 7'h40;
    step(2);
    rst = 1'b1;
    step(2);
    an  = 4'b1111;
    seg = 7'h7F;
    step(1);
    rst = 1'b0;
    step(8);
    check("rstmid_digits", 32'(digits), 32'd0);
    check("rstmid_valid", 32'(digit_valid), 32'd0);
    check("rstmid_err", 32'(err), 32'd0);
    check("rstmid_lost", 32'(lost), 32'd1);
    check("total_updates", upd_cnt, pushed);
    check("total_frame_done", fd_cnt, 2);
    check("pending_expectations", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
